flash_arbiter: RTL and testbench
================================

# flash_arbiter

Shares the single 2M x 32 sample flash between `NUM_REQ` requesters (voice playback, recorder, sample loader). It accepts one request per transaction with a valid/ready handshake and grants requesters round-robin. It drives the flash controller's address, data, write-enable and CE-request inputs, and returns read data with a one-cycle response strobe. It sits between the voice/record logic and `flashControl`.

## Interface
- `NUM_REQ`, 3: number of requesters (2..4).
- `AW`, 21: flash word-address width.
- `DW`, 32: flash data width.
- `CLK`  in  1  system clock, 100 MHz.
- `RESETN`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*AW  flattened addresses; requester i uses bits [i*AW +: AW].
- `req_wdata`  in  NUM_REQ*DW  flattened write data.
- `req_ready`  out  NUM_REQ  one-hot grant/accept.
- `rsp_valid`  out  NUM_REQ  one-hot completion strobe, 1 cycle.
- `rsp_rdata`  out  DW  flash data shared by all requesters; qualified by `rsp_valid`.
- `flash_addr`  out  AW  to the controller `address`.
- `flash_wdata`  out  DW  to `dataIn`.
- `flash_we`  out  1  to `writeEnable`.
- `flash_ce_req`  out  1  to `requestCE`.
- `flash_rdata`  in  DW  from `dataOut`.

## Operation
- FSM states:
  - IDLE: `req_ready` may assert. On accept, go to ISSUE.
  - ISSUE: go to RESP unconditionally.
  - RESP: go to IDLE unconditionally.
- Arbitration runs only in IDLE.
  - Search order starts at `last_grant+1` mod NUM_REQ; the first requester with `req_valid` wins.
  - `req_ready` is combinational, one-hot, and asserted only in IDLE.
  - An accept is `req_valid & req_ready`. On accept, `last_grant` takes the winner index.
- At the accept edge, register `req_addr`, `req_wdata` and `req_we` of the winner into `flash_addr`, `flash_wdata` and `flash_we`. Also register the winner index as `owner`.
- `flash_ce_req` is high in ISSUE and RESP and low in IDLE.
- `flash_we` is high in ISSUE only, and only for writes. It is forced low in RESP so that exactly one memory write occurs.
- In RESP:
  - `rsp_valid[owner]` = 1.
  - `rsp_rdata` = `flash_rdata`, passed through.
  - For writes, `rsp_rdata` holds the pre-write contents, because the controller reads and writes in the same cycle. Requesters ignore it.
- Requesters hold `req_*` stable while `req_valid` is high and not yet accepted. Dropping `req_valid` before accept is legal and loses nothing.
- Deassertion of `req_valid` after accept has no effect on the transaction.
- Reset:
  - All outputs are 0. State = IDLE. `last_grant` = NUM_REQ-1, so port 0 wins first.
  - Reset mid-transaction aborts it. No `rsp_valid` is issued. A write whose ISSUE cycle already completed stays in memory.

## Timing
- Cycle k: accept. Cycle k+1: ISSUE, and the flash samples the address. Cycle k+2: RESP, with `rsp_valid` and data valid.
- Read latency is 2 cycles from accept to `rsp_valid`. Write latency is also 2 cycles.
- Earliest next accept is cycle k+3. Sustained throughput is 1 transaction per 3 cycles.
- All requesters continuously valid: grants rotate 0,1,2,0,… with no requester waiting more than NUM_REQ transactions (≤ 3*NUM_REQ cycles).
- A new valid arriving during ISSUE/RESP is not seen until IDLE. No grant is made mid-transaction.

## Structure
- Shared package `flash_pkg`:
  - `FLASH_AW` = 21, `FLASH_DW` = 32.
  - FSM state encodings `ST_IDLE`, `ST_ISSUE`, `ST_RESP`.
  - Requester index constants `REQ_PLAY` = 0, `REQ_REC` = 1, `REQ_LOAD` = 2.
- Sub-module `rr_arbiter`: combinational round-robin pick. Inputs are the request vector and `last_grant`. Outputs are the one-hot grant and the index. The FSM, registers and muxing stay in `flash_arbiter`.

## Test plan
- After reset, only port 1 reads address 0x00010: `req_ready[1]` in cycle k, `flash_ce_req` high in k+1..k+2, `rsp_valid`=3'b010 in k+2 with the memory word; `flash_we` never high.
- Port 2 writes 0xDEADBEEF to 0x1FFFFF (top address), then port 0 reads 0x1FFFFF: write completes at k+2; read returns 0xDEADBEEF; `flash_we` high exactly one cycle.
- All three ports continuously valid for 9 transactions from reset: grant order 0,1,2,0,1,2,0,1,2; accepts 3 cycles apart; no port starved.
- Port 0 raises valid in the ISSUE cycle of a port 1 transaction: no `req_ready` until IDLE; port 0 accepted at k+3.
- `RESETN` low during RESP of a read: `rsp_valid`, `flash_ce_req` and `req_ready` drop to 0 immediately; after release, port 0 wins first.
- Port 1 drops `req_valid` in the same cycle port 2 is granted: no spurious accept for port 1; only port 2's response appears.

Source files
------------

// File: rtl/flash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flash_pkg
// Brief    : Shared flash geometry, arbiter FSM encodings and requester ids.
// Revision : 1.0
// ============================================================================
package flash_pkg;

    localparam int FLASH_AW = 21;
    localparam int FLASH_DW = 32;

    localparam int REQ_PLAY = 0;
    localparam int REQ_REC  = 1;
    localparam int REQ_LOAD = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/flash_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_arbiter_if
// Brief    : Requester-side request/response bus plus flash controller bus.
// Revision : 1.0
// ============================================================================
interface flash_arbiter_if
    import flash_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = FLASH_AW,
    parameter int DW      = FLASH_DW
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*AW-1:0] req_addr;
    logic [NUM_REQ*DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic [AW-1:0]         flash_addr;
    logic [DW-1:0]         flash_wdata;
    logic                  flash_we;
    logic                  flash_ce_req;
    logic [DW-1:0]         flash_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flash_rdata,
        output req_ready, rsp_valid, rsp_rdata,
               flash_addr, flash_wdata, flash_we, flash_ce_req
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, flash_rdata,
        input  req_ready, rsp_valid, rsp_rdata,
               flash_addr, flash_wdata, flash_we, flash_ce_req
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting after last_grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx,
    output logic               any
);
    int w_cand;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = (int'(last_grant) + k) % NUM_REQ;
            if (!any && req[w_cand]) begin
                any         = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = IW'(w_cand);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_arbiter
// Brief    : Round-robin sharing of the sample flash between requesters.
// Revision : 1.0
// ============================================================================
module flash_arbiter
    import flash_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int AW      = FLASH_AW,
    parameter int DW      = FLASH_DW
) (
    input  logic            CLK,
    input  logic            RESETN,
    flash_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      r_owner;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic               r_we;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_win_idx;
    logic               w_any;
    logic               w_accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (r_last),
        .gnt        (w_gnt),
        .idx        (w_win_idx),
        .any        (w_any)
    );

    assign w_accept = (r_state == ST_IDLE) && w_any;

    always_comb begin
        w_state_nxt      = r_state;
        bus.req_ready    = '0;
        bus.rsp_valid    = '0;
        bus.rsp_rdata    = '0;
        bus.flash_ce_req = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by RESETN so ready stays low while reset is held.
                if (RESETN) bus.req_ready = w_gnt;
                if (w_accept) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.flash_ce_req = 1'b1;
                w_state_nxt      = ST_RESP;
            end
            ST_RESP: begin
                bus.flash_ce_req       = 1'b1;
                bus.rsp_valid[r_owner] = 1'b1;
                bus.rsp_rdata          = bus.flash_rdata;
                w_state_nxt            = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= ST_IDLE;
            r_last  <= IW'(NUM_REQ - 1);
            r_owner <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last  <= w_win_idx;
                r_owner <= w_win_idx;
                r_addr  <= bus.req_addr[w_win_idx*AW +: AW];
                r_wdata <= bus.req_wdata[w_win_idx*DW +: DW];
                r_we    <= bus.req_we[w_win_idx];
            end else if (r_state == ST_ISSUE) begin
                // Write strobe lives for the ISSUE cycle only.
                r_we    <= 1'b0;
            end
        end
    end

    assign bus.flash_addr  = r_addr;
    assign bus.flash_wdata = r_wdata;
    assign bus.flash_we    = r_we;
endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_arbiter
// Brief    : Randomized and directed checks of flash_arbiter against a model.
// Revision : 1.0
// ============================================================================
module tb_flash_arbiter;
    import flash_pkg::*;

    localparam int N  = 3;
    localparam int AW = FLASH_AW;
    localparam int DW = FLASH_DW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    flash_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();

    flash_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {11'h5A3, a};
    endfunction

    // Flash controller: read-before-write, data valid the cycle after sampling.
    logic [DW-1:0] fmem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (bus.flash_ce_req) begin
            bus.flash_rdata <= fmem.exists(bus.flash_addr) ? fmem[bus.flash_addr]
                                                            : init_word(bus.flash_addr);
            if (bus.flash_we) fmem[bus.flash_addr] = bus.flash_wdata;
        end
    end

    // Reference model: one transaction = accept, issue, respond.
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            m_phase, m_last, m_port;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_pre;
    logic [N-1:0]  exp_ready, exp_rsp;
    logic          exp_ce, exp_we;
    logic [DW-1:0] exp_rdata;
    int            acc_port;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_last  = N - 1;
    endtask

    task automatic model_step();
        int bestd, d;
        exp_ready = '0; exp_rsp = '0; exp_ce = 1'b0; exp_we = 1'b0; acc_port = -1;
        bestd = N;
        if (m_phase == 0) begin
            for (int c = 0; c < N; c++) begin
                d = (c - m_last - 1 + 2*N) % N;
                if (bus.req_valid[c] && d < bestd) begin bestd = d; acc_port = c; end
            end
            if (acc_port >= 0) begin
                exp_ready[acc_port] = 1'b1;
                m_port  = acc_port;
                m_we    = bus.req_we[acc_port];
                m_addr  = bus.req_addr[acc_port*AW +: AW];
                m_wdata = bus.req_wdata[acc_port*DW +: DW];
                m_last  = acc_port;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            exp_ce = 1'b1;
            exp_we = m_we;
            m_pre  = ref_read(m_addr);
            if (m_we) ref_mem[m_addr] = m_wdata;
            m_phase = 2;
        end else begin
            exp_ce           = 1'b1;
            exp_rsp[m_port]  = 1'b1;
            exp_rdata        = m_pre;
            m_phase          = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        cyc++;
        model_step();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[p]          = 1'b1;
        bus.req_we[p]             = we;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req_valid = 3'b001;
        #2;
        n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset ready got=%b exp=000", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset rsp_valid got=%b exp=000", bus.rsp_valid); end
        n_tests++; if ({bus.flash_ce_req, bus.flash_we} !== 2'b00) begin n_fail++; $display("FAIL reset ce/we got=%b%b exp=00", bus.flash_ce_req, bus.flash_we); end
        n_tests++; if (bus.flash_addr !== '0 || bus.flash_wdata !== '0) begin n_fail++; $display("FAIL reset flash bus got=%h/%h exp=0/0", bus.flash_addr, bus.flash_wdata); end
        n_tests++; if (bus.rsp_rdata !== '0) begin n_fail++; $display("FAIL reset rsp_rdata got=%h exp=0", bus.rsp_rdata); end
        do_reset();
    endtask

    task automatic test_single_read();
        int k = -1, rc = -1, we_hits = 0;
        do_reset();
        set_req(REQ_REC, 1'b0, 21'h00010, '0);
        for (int i = 0; i < 6; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rd1 ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rd1 rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp); end
            n_tests++; if ({bus.flash_ce_req, bus.flash_we} !== {exp_ce, exp_we}) begin n_fail++; $display("FAIL rd1 ce/we cyc=%0d got=%b%b exp=%b%b", cyc, bus.flash_ce_req, bus.flash_we, exp_ce, exp_we); end
            if (bus.req_ready[1] && bus.req_valid[1]) k = cyc;
            if (bus.rsp_valid == 3'b010) begin
                rc = cyc;
                n_tests++; if (bus.rsp_rdata !== init_word(21'h00010)) begin n_fail++; $display("FAIL rd1 data got=%h exp=%h", bus.rsp_rdata, init_word(21'h00010)); end
            end
            if (bus.flash_we) we_hits++;
            next_cycle();
            if (k >= 0) bus.req_valid[1] = 1'b0;
        end
        n_tests++; if (k < 0 || rc != k + 2) begin n_fail++; $display("FAIL rd1 latency accept=%0d rsp=%0d exp_delta=2", k, rc); end
        n_tests++; if (we_hits != 0) begin n_fail++; $display("FAIL rd1 we_count got=%0d exp=0", we_hits); end
    endtask

    task automatic test_write_read();
        int kw = -1, kr = -1, rw = -1, we_hits = 0;
        logic got_read = 1'b0;
        do_reset();
        set_req(REQ_LOAD, 1'b1, 21'h1FFFFF, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL wr ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL wr rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp); end
            n_tests++; if ({bus.flash_ce_req, bus.flash_we} !== {exp_ce, exp_we}) begin n_fail++; $display("FAIL wr ce/we cyc=%0d got=%b%b exp=%b%b", cyc, bus.flash_ce_req, bus.flash_we, exp_ce, exp_we); end
            if (bus.flash_we) we_hits++;
            if (bus.req_ready[2] && bus.req_valid[2]) kw = cyc;
            if (bus.req_ready[0] && bus.req_valid[0]) kr = cyc;
            if (bus.rsp_valid == 3'b100) rw = cyc;
            if (bus.rsp_valid == 3'b001) begin
                got_read = 1'b1;
                n_tests++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr readback got=%h exp=deadbeef", bus.rsp_rdata); end
            end
            next_cycle();
            if (kw >= 0 && bus.req_valid[2]) begin
                bus.req_valid[2] = 1'b0;
                set_req(REQ_PLAY, 1'b0, 21'h1FFFFF, '0);
            end
            if (kr >= 0) bus.req_valid[0] = 1'b0;
        end
        n_tests++; if (kw < 0 || rw != kw + 2) begin n_fail++; $display("FAIL wr latency accept=%0d rsp=%0d exp_delta=2", kw, rw); end
        n_tests++; if (kr != kw + 3) begin n_fail++; $display("FAIL wr next_accept got=%0d exp=%0d", kr, kw + 3); end
        n_tests++; if (we_hits != 1 || !got_read) begin n_fail++; $display("FAIL wr we_count got=%0d exp=1 read_seen=%0d", we_hits, got_read); end
    endtask

    task automatic test_round_robin();
        int order[$];
        int acyc[$];
        do_reset();
        for (int p = 0; p < N; p++) set_req(p, 1'b0, 21'($urandom_range(0, 255)), '0);
        for (int i = 0; i < 40 && order.size() < 9; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rr ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            for (int p = 0; p < N; p++)
                if (bus.req_ready[p] && bus.req_valid[p]) begin order.push_back(p); acyc.push_back(cyc); end
            next_cycle();
            if (acc_port >= 0) bus.req_addr[acc_port*AW +: AW] = 21'($urandom_range(0, 255));
        end
        n_tests++; if (order.size() != 9) begin n_fail++; $display("FAIL rr accept_count got=%0d exp=9", order.size()); end
        for (int j = 0; j < order.size(); j++) begin
            n_tests++; if (order[j] != j % N) begin n_fail++; $display("FAIL rr order idx=%0d got=%0d exp=%0d", j, order[j], j % N); end
            if (j > 0) begin
                n_tests++; if (acyc[j] - acyc[j-1] != 3) begin n_fail++; $display("FAIL rr spacing idx=%0d got=%0d exp=3", j, acyc[j] - acyc[j-1]); end
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_late_valid();
        int k1 = -1, k0 = -1;
        do_reset();
        set_req(REQ_REC, 1'b0, 21'h00123, '0);
        for (int i = 0; i < 8; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL late ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL late rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp); end
            if (bus.req_ready[1] && bus.req_valid[1]) k1 = cyc;
            if (bus.req_ready[0] && bus.req_valid[0]) k0 = cyc;
            next_cycle();
            if (k1 >= 0 && bus.req_valid[1]) begin
                bus.req_valid[1] = 1'b0;
                set_req(REQ_PLAY, 1'b0, 21'h00456, '0);
            end
            if (k0 >= 0) bus.req_valid[0] = 1'b0;
        end
        n_tests++; if (k1 < 0 || k0 != k1 + 3) begin n_fail++; $display("FAIL late accept got=%0d exp=%0d", k0, k1 + 3); end
    endtask

    task automatic test_reset_mid();
        int k = -1;
        logic in_resp = 1'b0;
        do_reset();
        set_req(REQ_LOAD, 1'b0, 21'h00077, '0);
        for (int i = 0; i < 6 && !in_resp; i++) begin
            sample();
            if (bus.req_ready[2] && bus.req_valid[2]) k = cyc;
            if (k >= 0 && cyc == k + 2) in_resp = 1'b1;
            else begin
                next_cycle();
                if (k >= 0) begin bus.req_valid[2] = 1'b0; bus.req_valid[1:0] = 2'b11; end
            end
        end
        n_tests++; if (!in_resp || bus.rsp_valid !== 3'b100) begin n_fail++; $display("FAIL rstmid resp got=%b exp=100", bus.rsp_valid); end
        #1 rstn = 1'b0;
        #1;
        model_reset();
        n_tests++; if ({bus.rsp_valid, bus.flash_ce_req, bus.req_ready} !== 7'b0) begin n_fail++; $display("FAIL rstmid drop got=%b/%b/%b exp=0/0/0", bus.rsp_valid, bus.flash_ce_req, bus.req_ready); end
        @(posedge clk); #1 rstn = 1'b1;
        sample();
        n_tests++; if (bus.req_ready !== 3'b001 || bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rstmid first_grant got=%b exp=001", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL rstmid stale_rsp got=%b exp=000", bus.rsp_valid); end
        next_cycle();
        bus.req_valid = '0;
    endtask

    task automatic test_drop_valid();
        int k0 = -1, r1 = 0, r2 = 0;
        do_reset();
        set_req(REQ_PLAY, 1'b0, 21'h00020, '0);
        for (int i = 0; i < 10; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL drop ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL drop rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp); end
            if (bus.req_ready[0] && bus.req_valid[0]) k0 = cyc;
            if (bus.rsp_valid[1]) r1++;
            if (bus.rsp_valid[2]) r2++;
            next_cycle();
            if (k0 >= 0 && cyc == k0) begin
                bus.req_valid[0] = 1'b0;
                set_req(REQ_REC, 1'b0, 21'h00021, '0);
                set_req(REQ_LOAD, 1'b0, 21'h00022, '0);
            end
            if (k0 >= 0 && cyc == k0 + 2) bus.req_valid[1] = 1'b0;
            if (acc_port == 2) bus.req_valid[2] = 1'b0;
        end
        n_tests++; if (r1 != 0 || r2 != 1) begin n_fail++; $display("FAIL drop responses p1=%0d p2=%0d exp=0/1", r1, r2); end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sample();
            n_tests++; if (bus.req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready); end
            n_tests++; if (bus.rsp_valid !== exp_rsp) begin n_fail++; $display("FAIL rnd rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_rsp); end
            n_tests++; if ({bus.flash_ce_req, bus.flash_we} !== {exp_ce, exp_we}) begin n_fail++; $display("FAIL rnd ce/we cyc=%0d got=%b%b exp=%b%b", cyc, bus.flash_ce_req, bus.flash_we, exp_ce, exp_we); end
            if (exp_ce) begin
                n_tests++; if (bus.flash_addr !== m_addr || (exp_we && bus.flash_wdata !== m_wdata)) begin n_fail++; $display("FAIL rnd flash_bus cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.flash_addr, bus.flash_wdata, m_addr, m_wdata); end
            end
            if (exp_rsp != '0) begin
                n_tests++; if (bus.rsp_rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd rdata cyc=%0d got=%h exp=%h", cyc, bus.rsp_rdata, exp_rdata); end
            end
            next_cycle();
            for (int p = 0; p < N; p++) begin
                a = ($urandom_range(0, 3) == 0) ? 21'h1FFFFF : 21'($urandom_range(0, 7) + 'h100);
                if (acc_port == p) begin
                    if ($urandom_range(0, 1) == 1) set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
                    else bus.req_valid[p] = 1'b0;
                end else if (!bus.req_valid[p]) begin
                    if ($urandom_range(0, 2) == 0) set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[p] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_write_read();
        test_round_robin();
        test_late_valid();
        test_reset_mid();
        test_drop_valid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d exp=finish", cyc);
        $fatal(1);
    end
endmodule
`default_nettype wire
